// File: rtl/add_serial_digit.sv
// rtl/add_serial_digit.sv - digit-serial adder/subtractor with valid/ready operand and result handshakes
module add_serial_digit #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = $clog2(STEPS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ADD  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic              carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [CW-1:0]     count_q, count_d;

    logic [DIGIT:0]        digit_res;
    logic [WIDTH+DIGIT-1:0] sum_cat;
    logic                  last_step;
    logic                  msb_cin;

    assign digit_res = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    assign sum_cat   = {digit_res[DIGIT-1:0], sum_q};
    assign last_step = (count_q == CW'(STEPS - 1));
    // Carry into the top bit of the digit, recovered from its sum bit and operand bits.
    assign msb_cin   = digit_res[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid)  state_d = S_ADD;
            S_ADD:   if (last_step) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        busy      = (state_q == S_ADD) || (state_q == S_DONE);
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        count_d = count_q;
        if (state_q == S_IDLE && in_valid) begin
            // Subtraction is a + ~b + 1, so cin is replaced by the forced carry.
            a_d     = a;
            b_d     = sub ? ~b : b;
            carry_d = sub ? 1'b1 : cin;
            count_d = '0;
            sum_d   = '0;
        end else if (state_q == S_ADD) begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            sum_d   = sum_cat[WIDTH+DIGIT-1:DIGIT];
            carry_d = digit_res[DIGIT];
            count_d = count_q + CW'(1);
            if (last_step) begin
                cout_d = digit_res[DIGIT];
                ovf_d  = msb_cin ^ digit_res[DIGIT];
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_add_serial_digit.sv
// tb/tb_add_serial_digit.sv - directed self-checking bench for add_serial_digit
module tb_add_serial_digit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic        v0 = 0, r0 = 0, s0 = 0, c0 = 0, or0 = 0;
    logic [7:0]  a0 = 0, b0 = 0, sum0;
    logic        ir0, ov0, co0, of0, bz0;

    logic        v1 = 0, or1 = 0;
    logic [7:0]  a1 = 0, b1 = 0, sum1;
    logic        ir1, ov1, co1, of1, bz1;

    logic        v2 = 0, or2 = 0;
    logic [15:0] a2 = 0, b2 = 0, sum2;
    logic        ir2, ov2, co2, of2, bz2;

    add_serial_digit #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_ready(ir0), .a(a0), .b(b0),
        .sub(s0), .cin(c0), .out_valid(ov0), .out_ready(or0), .sum(sum0),
        .cout(co0), .ovf(of0), .busy(bz0));

    add_serial_digit #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(ir1), .a(a1), .b(b1),
        .sub(1'b0), .cin(1'b0), .out_valid(ov1), .out_ready(or1), .sum(sum1),
        .cout(co1), .ovf(of1), .busy(bz1));

    add_serial_digit #(.WIDTH(16), .DIGIT(8)) u_w16 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_ready(ir2), .a(a2), .b(b2),
        .sub(1'b0), .cin(1'b0), .out_valid(ov2), .out_ready(or2), .sum(sum2),
        .cout(co2), .ovf(of2), .busy(bz2));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one op to the W8/D1 instance; returns after the accept edge + 1.
    task automatic accept0(input logic [7:0] a, input logic [7:0] b, input logic sub, input logic cin);
        @(negedge clk);
        check_eq("in_ready_before_accept", ir0, 1);
        a0 = a; b0 = b; s0 = sub; c0 = cin; v0 = 1;
        @(posedge clk); #1;
        v0 = 0;
    endtask

    task automatic wait_done0(output int lat);
        lat = 0;
        while (!ov0 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic op0(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic sub, input logic cin,
                       input logic [7:0] es, input logic ec, input logic eo);
        int lat;
        accept0(a, b, sub, cin);
        check_eq({tag, "_busy"}, bz0, 1);
        wait_done0(lat);
        check_eq({tag, "_latency"}, lat, 8);
        check_eq({tag, "_sum"}, sum0, es);
        check_eq({tag, "_cout"}, co0, ec);
        check_eq({tag, "_ovf"}, of0, eo);
        or0 = 1;
        @(posedge clk); #1;
        or0 = 0;
        check_eq({tag, "_drain_in_ready"}, ir0, 1);
        check_eq({tag, "_drain_out_valid"}, ov0, 0);
    endtask

    initial begin
        int lat;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        check_eq("rst_in_ready", ir0, 1);
        check_eq("rst_out_valid", ov0, 0);
        check_eq("rst_busy", bz0, 0);
        check_eq("rst_sum", sum0, 0);
        check_eq("rst_cout", co0, 0);
        check_eq("rst_ovf", of0, 0);

        op0("add_7f_01", 8'h7F, 8'h01, 0, 0, 8'h80, 0, 1);
        op0("sub_05_07", 8'h05, 8'h07, 1, 0, 8'hFE, 0, 0);
        op0("sub_80_01", 8'h80, 8'h01, 1, 0, 8'h7F, 1, 1);
        op0("add_ff_01_cin", 8'hFF, 8'h01, 0, 1, 8'h01, 1, 0);
        op0("sub_cin_ignored", 8'h10, 8'h10, 1, 1, 8'h00, 1, 0);
        op0("add_40_40", 8'h40, 8'h40, 0, 0, 8'h80, 0, 1);

        // Backpressure: result held, new operands refused while in DONE.
        accept0(8'h12, 8'h34, 0, 0);
        wait_done0(lat);
        check_eq("bp_latency", lat, 8);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            v0 = 1; a0 = 8'hA0 + 8'(i); b0 = 8'h01;
            @(posedge clk); #1;
            v0 = 0;
            check_eq("bp_out_valid", ov0, 1);
            check_eq("bp_in_ready", ir0, 0);
            check_eq("bp_sum", sum0, 8'h46);
            check_eq("bp_cout", co0, 0);
        end
        or0 = 1;
        @(posedge clk); #1;
        or0 = 0;
        check_eq("bp_release_in_ready", ir0, 1);
        check_eq("bp_release_out_valid", ov0, 0);
        check_eq("bp_idle_sum_held", sum0, 8'h46);

        // Reset in the middle of ADD discards the operation.
        accept0(8'h55, 8'h22, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1;
        rst = 0;
        check_eq("midrst_in_ready", ir0, 1);
        check_eq("midrst_out_valid", ov0, 0);
        check_eq("midrst_busy", bz0, 0);
        check_eq("midrst_sum", sum0, 0);
        op0("post_rst_add", 8'h21, 8'h13, 0, 0, 8'h34, 0, 0);

        // W8/D4
        @(negedge clk);
        a1 = 8'h3C; b1 = 8'h05; v1 = 1;
        @(posedge clk); #1;
        v1 = 0;
        lat = 0;
        while (!ov1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("d4_latency", lat, 2);
        check_eq("d4_sum", sum1, 8'h41);
        check_eq("d4_cout", co1, 0);
        check_eq("d4_ovf", of1, 0);
        or1 = 1;
        @(posedge clk); #1;
        or1 = 0;
        check_eq("d4_drain_in_ready", ir1, 1);

        // W16/D8
        @(negedge clk);
        a2 = 16'hFFFF; b2 = 16'h0001; v2 = 1;
        @(posedge clk); #1;
        v2 = 0;
        lat = 0;
        while (!ov2 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("w16_latency", lat, 2);
        check_eq("w16_sum", sum2, 16'h0000);
        check_eq("w16_cout", co2, 1);
        check_eq("w16_ovf", of2, 0);
        or2 = 1;
        @(posedge clk); #1;
        or2 = 0;
        check_eq("w16_drain_out_valid", ov2, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
